mem_arbiter: RTL
================

// Module: mem_arbiter
// PURPOSE
//  Sits between the two cache-fill paths (I-cache fill, D-cache fill/write) and the single
//  pipelined main memory (memory4c). Grants the memory port to one requester at a time,
//  forwards its address/write traffic, and routes returning read data (mem_valid) back to
//  the owner. Lock is held for a whole burst; the owner changes only after in-flight reads drain.
// PARAMETERS
//  ADDR_W   16  address width
//  DATA_W   16  data width
//  MEM_LAT  4   cycles from mem_en (read) to mem_valid; memory accepts one request per cycle
// PORTS
//  clk        in   1       clock
//  rst        in   1       synchronous reset, active high
//  i_req      in   1       I-fill requests / holds memory port
//  i_addr     in   ADDR_W  I-fill read address (valid while i_req & i_gnt)
//  i_gnt      out  1       I-fill owns memory port this cycle
//  i_rvalid   out  1       rdata is a read return for I-fill
//  d_req      in   1       D-side requests / holds memory port
//  d_wr       in   1       1 = write (single word), 0 = read
//  d_addr     in   ADDR_W  D-side address
//  d_wdata    in   DATA_W  D-side write data
//  d_gnt      out  1       D-side owns memory port this cycle
//  d_rvalid   out  1       rdata is a read return for D-side
//  rdata      out  DATA_W  read data (= mem_rdata, qualified by i_rvalid/d_rvalid)
//  mem_en     out  1       memory enable
//  mem_wr     out  1       memory write
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data
//  mem_valid  in   1       memory read data valid
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, owner=none, inflight=0, last=I; all outputs 0.
//  - States: IDLE, OWN_I, OWN_D, DRAIN. i_gnt=(state==OWN_I), d_gnt=(state==OWN_D); registered.
//  - IDLE: i_req&d_req -> OWN_I (fixed priority, I>D); only one req -> that owner; none -> IDLE.
//    Grant appears the cycle after req; no memory traffic issued in IDLE.
//  - OWN_x with x_req=1: combinational issue: mem_en=1, mem_addr=x_addr;
//    for D: mem_wr=d_wr, mem_wdata=d_wdata. I never writes (mem_wr=0).
//  - OWN_x with x_req=0: no issue (mem_en=0); -> DRAIN if inflight!=0, else -> IDLE.
//  - DRAIN: mem_en=0, no grants; -> IDLE when inflight==0 (incl. same-cycle last mem_valid).
//  - inflight counter, width $clog2(MEM_LAT+1): +1 on read issue (mem_en & ~mem_wr),
//    -1 on mem_valid, both same cycle -> unchanged. Never exceeds MEM_LAT; mem_valid with
//    inflight==0 is ignored (no rvalid, counter stays 0, no underflow).
//  - Read return: rdata=mem_rdata always; i_rvalid=mem_valid&(owner==I)&(inflight!=0),
//    d_rvalid likewise for D. owner register is updated only on entry to OWN_x, so
//    returns during DRAIN still reach the old owner.
//  - Writes are posted: not counted, no rvalid.
//  - Reset mid-burst: everything returns to reset values next cycle; late mem_valid ignored.
//  - Owner cannot be preempted: other req waits until IDLE, then arbitrates.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: IDLE with both reqs grants the requester not served last
//    ('last' register, set on entry to OWN_x); single req unaffected.
//  Undefined: fixed priority I>D; 'last' register not built.
// TESTING
//  1 Reset: rst=1 2 cycles -> all outputs 0, busy=0; rst=0 with no req -> stays IDLE.
//  2 I burst: i_req=1 for 8 cycles addr 0x0400..0x040E -> i_gnt from cycle 1, 8 mem_en reads,
//    8 i_rvalid MEM_LAT cycles after each, DRAIN then IDLE; d_rvalid never 1.
//  3 Both req in same cycle from IDLE -> OWN_I first; D granted after I drains; with
//    MEM_ARB_RR_EN and last=I, D granted first.
//  4 D write: d_req=1,d_wr=1,addr 0x1234,wdata 0xBEEF one cycle -> mem_wr=1 mem_addr=0x1234
//    mem_wdata=0xBEEF; next state IDLE directly (inflight=0), no rvalid.
//  5 Drop req mid-burst after 3 reads -> DRAIN, exactly 3 rvalids to owner, then IDLE.
//  6 rst pulse with 2 reads in flight -> IDLE next cycle; subsequent mem_valid yields no rvalid.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the I-fill, D-side and main-memory signals that meet at
// the memory arbiter. The slave modport is the arbiter's view; the master modport is
// the view of everything around it (both requesters and the memory).
interface mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_gnt;
   logic              i_rvalid;
   logic              d_req;
   logic              d_wr;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] rdata;
   logic              mem_en;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              mem_valid;
   logic              busy;

   modport slave (
      input  i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
      output i_gnt, i_rvalid, d_gnt, d_rvalid, rdata, mem_en, mem_wr, mem_addr,
             mem_wdata, busy
   );

   modport master (
      output i_req, i_addr, d_req, d_wr, d_addr, d_wdata, mem_rdata, mem_valid,
      input  i_gnt, i_rvalid, d_gnt, d_rvalid, rdata, mem_en, mem_wr, mem_addr,
             mem_wdata, busy
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one pipelined main memory between the I-cache fill path and
// the D-cache fill/write path. The owner keeps the port for a whole burst; ownership
// only changes after every outstanding read has come back, so returning data always
// reaches the requester that issued it.
// Optional feature: define MEM_ARB_RR_EN to alternate between requesters when both
// ask in the same IDLE cycle (default build: fixed priority, I-fill first).
module mem_arbiter #(
   parameter int ADDR_W  = 16,
   parameter int DATA_W  = 16,
   parameter int MEM_LAT = 4
) (
   input logic           clk,
   input logic           rst,
   mem_arbiter_if.slave  bus
);

   localparam int INF_W = $clog2(MEM_LAT + 1);
   localparam logic [INF_W-1:0] INF_ZERO = {INF_W{1'b0}};
   localparam logic [INF_W-1:0] INF_ONE  = INF_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_OWN_I = 2'd1,
      ST_OWN_D = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      OWNER_NONE = 2'd0,
      OWNER_I    = 2'd1,
      OWNER_D    = 2'd2
   } owner_t;

   state_t            state_r;
   owner_t            owner_r;
   logic              iGnt_r;
   logic              dGnt_r;
   logic              busy_r;
   logic [INF_W-1:0]  inflight_r;
   logic [INF_W-1:0]  inflightNext_s;

   logic              memEn_s;
   logic              memWr_s;
   logic [ADDR_W-1:0] memAddr_s;
   logic [DATA_W-1:0] memWdata_s;
   logic              readIssue_s;
   logic              retire_s;

   logic              pickI_s;
   logic              enterI_s;
   logic              enterD_s;

`ifdef MEM_ARB_RR_EN
   // Set when the D-side was the most recent owner; reset means "I served last".
   logic              lastD_r;

   assign pickI_s = bus.i_req & (~bus.d_req | lastD_r);

   // Track which requester was granted most recently, updated on entry to ownership.
   always_ff @(posedge clk) begin
      if (rst) begin
         lastD_r <= 1'b0;
      end else if (enterI_s) begin
         lastD_r <= 1'b0;
      end else if (enterD_s) begin
         lastD_r <= 1'b1;
      end else begin
         lastD_r <= lastD_r;
      end
   end
`else
   assign pickI_s = bus.i_req;
`endif

   assign enterI_s = (state_r == ST_IDLE) & pickI_s;
   assign enterD_s = (state_r == ST_IDLE) & ~pickI_s & bus.d_req;

   // Forward the owner's request straight onto the memory port while it holds req.
   always_comb begin
      memEn_s    = 1'b0;
      memWr_s    = 1'b0;
      memAddr_s  = {ADDR_W{1'b0}};
      memWdata_s = {DATA_W{1'b0}};
      case (state_r)
         ST_OWN_I: begin
            if (bus.i_req) begin
               memEn_s   = 1'b1;
               memAddr_s = bus.i_addr;
            end else begin
               memEn_s   = 1'b0;
            end
         end
         ST_OWN_D: begin
            if (bus.d_req) begin
               memEn_s    = 1'b1;
               memWr_s    = bus.d_wr;
               memAddr_s  = bus.d_addr;
               memWdata_s = bus.d_wdata;
            end else begin
               memEn_s    = 1'b0;
            end
         end
         default: begin
            memEn_s = 1'b0;
         end
      endcase
   end

   // Reads count up when issued and down when returned; stray returns never underflow.
   assign readIssue_s = memEn_s & ~memWr_s;
   assign retire_s    = bus.mem_valid & (inflight_r != INF_ZERO);

   // Next value of the outstanding-read counter.
   always_comb begin
      inflightNext_s = inflight_r;
      case ({readIssue_s, retire_s})
         2'b10:   inflightNext_s = inflight_r + INF_ONE;
         2'b01:   inflightNext_s = inflight_r - INF_ONE;
         default: inflightNext_s = inflight_r;
      endcase
   end

   // Outstanding-read counter register.
   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_r <= INF_ZERO;
      end else begin
         inflight_r <= inflightNext_s;
      end
   end

   // Ownership FSM with registered grant/busy outputs; owner latches on entry only.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
         owner_r <= OWNER_NONE;
         iGnt_r  <= 1'b0;
         dGnt_r  <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (enterI_s) begin
                  state_r <= ST_OWN_I;
                  owner_r <= OWNER_I;
                  iGnt_r  <= 1'b1;
                  dGnt_r  <= 1'b0;
                  busy_r  <= 1'b1;
               end else if (enterD_s) begin
                  state_r <= ST_OWN_D;
                  owner_r <= OWNER_D;
                  iGnt_r  <= 1'b0;
                  dGnt_r  <= 1'b1;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
                  iGnt_r  <= 1'b0;
                  dGnt_r  <= 1'b0;
                  busy_r  <= 1'b0;
               end
            end
            ST_OWN_I: begin
               if (bus.i_req) begin
                  state_r <= ST_OWN_I;
               end else if (inflight_r != INF_ZERO) begin
                  state_r <= ST_DRAIN;
                  iGnt_r  <= 1'b0;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
                  iGnt_r  <= 1'b0;
                  busy_r  <= 1'b0;
               end
            end
            ST_OWN_D: begin
               if (bus.d_req) begin
                  state_r <= ST_OWN_D;
               end else if (inflight_r != INF_ZERO) begin
                  state_r <= ST_DRAIN;
                  dGnt_r  <= 1'b0;
                  busy_r  <= 1'b1;
               end else begin
                  state_r <= ST_IDLE;
                  dGnt_r  <= 1'b0;
                  busy_r  <= 1'b0;
               end
            end
            ST_DRAIN: begin
               // The last return may land in this same cycle.
               if (inflightNext_s == INF_ZERO) begin
                  state_r <= ST_IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  state_r <= ST_DRAIN;
                  busy_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               iGnt_r  <= 1'b0;
               dGnt_r  <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.i_gnt     = iGnt_r;
   assign bus.d_gnt     = dGnt_r;
   assign bus.busy      = busy_r;
   assign bus.mem_en    = memEn_s;
   assign bus.mem_wr    = memWr_s;
   assign bus.mem_addr  = memAddr_s;
   assign bus.mem_wdata = memWdata_s;
   assign bus.rdata     = bus.mem_rdata;
   assign bus.i_rvalid  = bus.mem_valid & (owner_r == OWNER_I) & (inflight_r != INF_ZERO);
   assign bus.d_rvalid  = bus.mem_valid & (owner_r == OWNER_D) & (inflight_r != INF_ZERO);

endmodule
